pc_sequencer: RTL

Program-counter register and next-PC sequencer for the single-cycle processor. Each cycle it selects between the sequential address (PC+4) and the branch/jump target produced by the flow-control and offset-adder stage. It holds the PC while instruction or data memory signals busywait, and remembers a redirect decision that arrives during a stall. It drives the instruction-memory address, feeds PC+4 back to the offset adder, and keeps a retired-instruction counter for the bench.

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer: PC+4 or branch target each cycle,
// holds through memory busywait and remembers a redirect that arrives during a stall.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   TAKEN,
    input  logic [31:0]            TARGET,
    input  logic                   IBUSY,
    input  logic                   DBUSY,
    output logic [31:0]            PC,
    output logic [31:0]            PC_PLUS4,
    output logic                   FETCH_EN,
    output logic                   RETIRED,
    output logic                   REDIRECT,
    output logic                   ALIGN_ERR,
    output logic [COUNT_WIDTH-1:0] RETIRE_COUNT
);

    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_PEND  = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [ADDR_W-1:0]      pending;
    logic [ADDR_W-1:0]      pending_next;
    logic [ADDR_W-1:0]      pc_next;
    logic                   fetch_next;
    logic                   retired_next;
    logic                   redirect_next;
    logic                   align_next;
    logic [COUNT_WIDTH-1:0] count_next;
    logic [ADDR_W-1:0]      load_addr;
    logic                   do_commit;
    logic                   do_load;
    logic                   stall;

    assign stall    = IBUSY | DBUSY;
    assign PC_PLUS4 = PC + ADDR_W'(4);

    // Next-state and next-output decode; a commit either loads a target or steps by 4.
    always_comb begin
        state_next    = state;
        pending_next  = pending;
        pc_next       = PC;
        fetch_next    = FETCH_EN;
        retired_next  = 1'b0;
        redirect_next = 1'b0;
        align_next    = ALIGN_ERR;
        count_next    = RETIRE_COUNT;
        load_addr     = TARGET;
        do_commit     = 1'b0;
        do_load       = 1'b0;

        case (state)
            S_BOOT: begin
                fetch_next = 1'b1;
                state_next = S_RUN;
            end
            S_RUN, S_STALL: begin
                if (!stall) begin
                    do_commit  = 1'b1;
                    do_load    = TAKEN;
                    state_next = S_RUN;
                end else if (TAKEN) begin
                    pending_next = TARGET;
                    state_next   = S_PEND;
                end else begin
                    state_next = S_STALL;
                end
            end
            S_PEND: begin
                // Captured target wins over whatever is on TAKEN/TARGET at release.
                if (!stall) begin
                    do_commit  = 1'b1;
                    do_load    = 1'b1;
                    load_addr  = pending;
                    state_next = S_RUN;
                end
            end
            default: state_next = S_BOOT;
        endcase

        if (do_commit) begin
            retired_next = 1'b1;
            if (RETIRE_COUNT != {COUNT_WIDTH{1'b1}}) begin
                count_next = RETIRE_COUNT + COUNT_WIDTH'(1);
            end
            if (do_load) begin
                pc_next       = {load_addr[ADDR_W-1:2], 2'b00};
                redirect_next = 1'b1;
                if (load_addr[1:0] != 2'b00) begin
                    align_next = 1'b1;
                end
            end else begin
                pc_next = PC_PLUS4;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_BOOT;
            pending      <= '0;
            PC           <= RESET_PC;
            FETCH_EN     <= 1'b0;
            RETIRED      <= 1'b0;
            REDIRECT     <= 1'b0;
            ALIGN_ERR    <= 1'b0;
            RETIRE_COUNT <= '0;
        end else begin
            state        <= state_next;
            pending      <= pending_next;
            PC           <= pc_next;
            FETCH_EN     <= fetch_next;
            RETIRED      <= retired_next;
            REDIRECT     <= redirect_next;
            ALIGN_ERR    <= align_next;
            RETIRE_COUNT <= count_next;
        end
    end

endmodule
